// File: rtl/common_pkg.sv
// Shared definitions for the SPI controller slice: word width and controller states.
package common_pkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_LO,
    SCK_HI,
    HELD,
    CS_HOLD,
    CS_GAP
  } spi_ctl_state_t;

endpackage

// File: rtl/spi_sck_div.sv
// Loadable half-period counter: emits a one-cycle tick every DIV cycles while enabled.
module spi_sck_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic load,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  // A load restarts the half period, so it suppresses a coincident tick.
  assign tick = en && !load && (cnt_q == '0);

  // Count DIV-1 down to 0, reloading on load or at each tick.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= RELOAD;
    end else if (load || tick) begin
      cnt_q <= RELOAD;
    end else if (en) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/spi_controller.sv
// SPI mode 0 initiator: shifts one word MSB-first per request, captures SDI, drives CS_N/SCK.
module spi_controller
  import common_pkg::*;
#(
  parameter int SCK_DIV = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  start_i,
  input  logic                  hold_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  spi_cs_no,
  output logic                  spi_sck_o,
  output logic                  spi_sd_o,
  input  logic                  spi_sd_i
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  spi_ctl_state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, data_q, data_d;
  logic [BW-1:0] bit_q, bit_d;
  logic hold_q, hold_d;
  logic cs_q, cs_d, sck_q, sck_d, sd_q, sd_d;
  logic ready_q, ready_d, valid_q, valid_d;
  logic accept, div_en, div_load, tick;

  assign accept = start_i && ready_q;
  // HELD parks the divider so a restart or release begins a fresh half period.
  assign div_en = (state_q != IDLE) && (state_q != HELD);

  spi_sck_div #(.DIV(SCK_DIV)) u_div (
    .clk     (clk_i),
    .reset_n (reset_ni),
    .en      (div_en),
    .load    (div_load),
    .tick    (tick)
  );

  // Next-state and next-output logic; every pin is registered below.
  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    data_d   = data_q;
    bit_d    = bit_q;
    hold_d   = hold_q;
    cs_d     = cs_q;
    sck_d    = sck_q;
    sd_d     = sd_q;
    ready_d  = ready_q;
    valid_d  = 1'b0;
    div_load = 1'b0;
    case (state_q)
      IDLE, HELD: begin
        if (accept) begin
          // A new request wins over a release in HELD; its own hold bit decides afterwards.
          state_d  = (state_q == IDLE) ? SETUP : SCK_LO;
          tx_d     = data_i;
          hold_d   = hold_i;
          ready_d  = 1'b0;
          cs_d     = 1'b0;
          sd_d     = data_i[DATA_WIDTH-1];
          bit_d    = '0;
          div_load = 1'b1;
        end else if (state_q == HELD && !hold_i) begin
          state_d  = CS_HOLD;
          ready_d  = 1'b0;
          div_load = 1'b1;
        end
      end
      SETUP, SCK_LO: begin
        if (tick) begin
          state_d = SCK_HI;
          sck_d   = 1'b1;
          rx_d    = {rx_q[DATA_WIDTH-2:0], spi_sd_i};
        end
      end
      SCK_HI: begin
        if (tick) begin
          sck_d = 1'b0;
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            data_d  = rx_q;
            valid_d = 1'b1;
            if (hold_q) begin
              state_d = HELD;
              ready_d = 1'b1;
            end else begin
              state_d = CS_HOLD;
            end
          end else begin
            // SDO only moves on the falling edge, giving the peripheral a full low phase of setup.
            state_d = SCK_LO;
            bit_d   = bit_q + BW'(1);
            sd_d    = tx_q[DATA_WIDTH-2];
            tx_d    = {tx_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end
      CS_HOLD: begin
        if (tick) begin
          state_d = CS_GAP;
          cs_d    = 1'b1;
        end
      end
      CS_GAP: begin
        if (tick) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and pin registers; reset aborts any word in progress on the same edge.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      bit_q   <= '0;
      cs_q    <= 1'b1;
      sck_q   <= 1'b0;
      sd_q    <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      sd_q    <= sd_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  // Shift registers and captured hold flag; only meaningful after an accept.
  always_ff @(posedge clk_i) begin
    tx_q   <= tx_d;
    rx_q   <= rx_d;
    hold_q <= hold_d;
  end

  assign ready_o   = ready_q;
  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign spi_cs_no = cs_q;
  assign spi_sck_o = sck_q;
  assign spi_sd_o  = sd_q;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: peripheral shift-core model plus scoreboards on both sides of the bus.
module tb_spi_controller;
  import common_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic start_i, hold_i, ready_o, valid_o, spi_cs_no, spi_sck_o, spi_sd_o, spi_sd_i;
  logic [7:0] data_i, data_o;
  logic start2_i, hold2_i, ready2_o, valid2_o, cs2_n, sck2, sdo2, sdi2;
  logic [7:0] data2_i, data2_o;

  spi_controller #(.SCK_DIV(4)) dut (
    .clk_i(clk), .reset_ni(reset_n), .start_i(start_i), .hold_i(hold_i), .data_i(data_i),
    .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .spi_cs_no(spi_cs_no),
    .spi_sck_o(spi_sck_o), .spi_sd_o(spi_sd_o), .spi_sd_i(spi_sd_i));

  spi_controller #(.SCK_DIV(2)) dut2 (
    .clk_i(clk), .reset_ni(reset_n), .start_i(start2_i), .hold_i(hold2_i), .data_i(data2_i),
    .ready_o(ready2_o), .data_o(data2_o), .valid_o(valid2_o), .spi_cs_no(cs2_n),
    .spi_sck_o(sck2), .spi_sd_o(sdo2), .spi_sd_i(sdi2));

  assign sdi2 = sdo2;

  int checks = 0, errors = 0, cyc = 0;
  logic [7:0] resp_q[$], exp_q[$], ptx_q[$], exp2_q[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [7:0] pop_resp();
    if (resp_q.size() != 0) return resp_q.pop_front();
    return 8'h00;
  endfunction

  always @(posedge clk) cyc++;

  // Peripheral shift core (SCK domain): loads on CS fall and after each completed word.
  logic [7:0] pshift = 8'h00, prx = 8'h00;
  int pcnt = 0, p_words = 0;
  logic pnext = 1'b0;
  assign spi_sd_i = pshift[7];

  always @(negedge spi_cs_no) begin
    pshift = pop_resp();
    pcnt = 0;
    pnext = 1'b0;
  end
  always @(posedge spi_cs_no) begin
    pcnt = 0;
    pnext = 1'b0;
  end
  always @(posedge spi_sck_o) if (!spi_cs_no) begin
    prx = {prx[6:0], spi_sd_o};
    pcnt++;
    if (pcnt == 8) begin
      pcnt = 0;
      pnext = 1'b1;
      p_words++;
      if (ptx_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL periph_rx: unexpected word got 0x%0h, expected none", prx);
      end else chk("periph_rx", 32'(prx), 32'(ptx_q.pop_front()));
    end
  end
  always @(negedge spi_sck_o) if (!spi_cs_no) begin
    if (pnext) begin
      pshift = pop_resp();
      pnext = 1'b0;
    end else pshift = {pshift[6:0], 1'b0};
  end

  // Output monitors, sampled on the falling clock edge.
  int valid_cnt = 0, valid_cyc = -1, cs_rise_cyc = -1, cs_rise_cnt = 0, ready_rise_cyc = -1;
  int sck_edges = 0, sck_rises = 0;
  logic prev_cs = 1'b1, prev_sck = 1'b0, prev_ready = 1'b1;
  int valid2_cnt = 0, sck2_edges = 0, run2 = 0, phase2_err = 0;
  logic prev_cs2 = 1'b1, prev_sck2 = 1'b0;

  always @(negedge clk) begin
    if (valid_o === 1'b1) begin
      valid_cnt++;
      valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL data_o: unexpected valid_o got 0x%0h, expected none", data_o);
      end else chk("data_o", 32'(data_o), 32'(exp_q.pop_front()));
    end
    if (spi_cs_no === 1'b1 && prev_cs === 1'b0) begin
      cs_rise_cyc = cyc;
      cs_rise_cnt++;
    end
    if (ready_o === 1'b1 && prev_ready === 1'b0) ready_rise_cyc = cyc;
    if (spi_sck_o !== prev_sck && reset_n === 1'b1) begin
      sck_edges++;
      if (spi_sck_o === 1'b1) sck_rises++;
    end
    prev_cs = spi_cs_no; prev_sck = spi_sck_o; prev_ready = ready_o;

    if (valid2_o === 1'b1) begin
      valid2_cnt++;
      if (exp2_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL data2_o: unexpected valid_o got 0x%0h, expected none", data2_o);
      end else chk("data2_o_loopback", 32'(data2_o), 32'(exp2_q.pop_front()));
    end
    if (sck2 !== prev_sck2 && reset_n === 1'b1) sck2_edges++;
    if (cs2_n === 1'b0) begin
      if (prev_cs2 === 1'b0 && sck2 === prev_sck2) run2++;
      else begin
        if (prev_cs2 === 1'b0 && run2 != 2) phase2_err++;
        run2 = 1;
      end
    end else if (prev_cs2 === 1'b0) begin
      if (run2 != 2) phase2_err++;
      run2 = 0;
    end
    prev_cs2 = cs2_n; prev_sck2 = sck2;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (ready_o !== 1'b1 && n < 300) begin step(); n++; end
    if (ready_o !== 1'b1) chk(name, 32'(ready_o), 32'd1);
  endtask

  // Issue one word; c0 returns the accept edge number (cycle 0 of the transfer).
  task automatic start_word(input logic [7:0] d, input logic h, input logic [7:0] r, output int c0);
    wait_ready("ready_timeout");
    start_i = 1'b1; data_i = d; hold_i = h;
    exp_q.push_back(r);
    ptx_q.push_back(d);
    @(posedge clk);
    #1;
    c0 = cyc;
    start_i = 1'b0;
  endtask

  typedef struct packed { logic [7:0] tx; logic [7:0] rx; } vec_t;
  vec_t tbl[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int c0, c1, c2, base, n, pw0, v0, e0;
    logic [7:0] w2[3];
    tbl[0] = '{8'hA5, 8'h3C};
    tbl[1] = '{8'h00, 8'hFF};
    tbl[2] = '{8'hFF, 8'h00};
    tbl[3] = '{8'h5A, 8'h81};
    tbl[4] = '{8'h01, 8'h80};
    w2 = '{8'h6D, 8'hB2, 8'h0F};

    reset_n = 1'b0; start_i = 1'b0; hold_i = 1'b0; data_i = 8'h00;
    start2_i = 1'b0; hold2_i = 1'b0; data2_i = 8'h00;
    repeat (3) step();
    chk("rst_cs_n", 32'(spi_cs_no), 32'd1);
    chk("rst_sck", 32'(spi_sck_o), 32'd0);
    chk("rst_sdo", 32'(spi_sd_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_data_o", 32'(data_o), 32'd0);
    reset_n = 1'b1;
    repeat (2) step();

    // Single words with release after each one.
    for (int i = 0; i < 5; i++) begin
      resp_q.push_back(tbl[i].rx);
      start_word(tbl[i].tx, 1'b0, tbl[i].rx, c0);
      step();
      wait_ready("single_ready_timeout");
      chk("single_valid_cycle", 32'(valid_cyc), 32'(c0 + 64));
      chk("single_cs_rise_cycle", 32'(cs_rise_cyc), 32'(c0 + 68));
      chk("single_ready_cycle", 32'(ready_rise_cyc), 32'(c0 + 72));
    end

    // Held burst of three words under one CS_N assertion.
    resp_q.push_back(8'h11); resp_q.push_back(8'h22); resp_q.push_back(8'h33);
    base = cs_rise_cnt; pw0 = p_words;
    start_word(8'h01, 1'b1, 8'h11, c0);
    step();
    wait_ready("burst_ready_timeout");
    chk("burst_held_ready_cycle", 32'(ready_rise_cyc), 32'(c0 + 64));
    start_word(8'h80, 1'b1, 8'h22, c1);
    chk("burst_restart_cycle", 32'(c1), 32'(c0 + 65));
    start_word(8'hFF, 1'b0, 8'h33, c2);
    step();
    wait_ready("burst_end_timeout");
    chk("burst_cs_rises", 32'(cs_rise_cnt - base), 32'd1);
    chk("burst_cs_after_valid", 32'(cs_rise_cyc), 32'(valid_cyc + 4));
    chk("burst_valid_cycle", 32'(valid_cyc), 32'(c2 + 64));
    chk("burst_periph_words", 32'(p_words - pw0), 32'd3);

    // Release from HELD without a new request.
    resp_q.push_back(8'h5A);
    start_word(8'hC3, 1'b1, 8'h5A, c0);
    step();
    wait_ready("held_ready_timeout");
    e0 = sck_edges;
    repeat (5) step();
    chk("held_cs_low", 32'(spi_cs_no), 32'd0);
    hold_i = 1'b0;
    n = cyc;
    step();
    c1 = 0;
    while (spi_cs_no !== 1'b1 && c1 < 50) begin step(); c1++; end
    wait_ready("release_ready_timeout");
    chk("release_cs_cycle", 32'(cs_rise_cyc), 32'(n + 5));
    chk("release_ready_cycle", 32'(ready_rise_cyc), 32'(n + 9));
    chk("release_no_sck", 32'(sck_edges), 32'(e0));

    // Reset after the third rising SCK aborts the word.
    resp_q.push_back(8'h77);
    base = sck_rises; v0 = valid_cnt;
    start_word(8'h96, 1'b0, 8'h77, c0);
    n = 0;
    while (sck_rises < base + 3 && n < 100) begin step(); n++; end
    chk("abort_third_rise", 32'(sck_rises - base), 32'd3);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_cs_n", 32'(spi_cs_no), 32'd1);
    chk("abort_sck", 32'(spi_sck_o), 32'd0);
    chk("abort_ready", 32'(ready_o), 32'd1);
    chk("abort_valid", 32'(valid_o), 32'd0);
    reset_n = 1'b1;
    exp_q.delete(); ptx_q.delete(); resp_q.delete();
    repeat (10) step();
    chk("abort_no_valid", 32'(valid_cnt - v0), 32'd0);
    resp_q.push_back(8'hC6);
    start_word(8'h3B, 1'b0, 8'hC6, c0);
    step();
    wait_ready("post_abort_timeout");
    chk("post_abort_valid_cycle", 32'(valid_cyc), 32'(c0 + 64));

    // Request while busy is ignored.
    resp_q.push_back(8'h4E);
    v0 = valid_cnt; pw0 = p_words;
    start_word(8'hD2, 1'b0, 8'h4E, c0);
    while (cyc < c0 + 9) step();
    start_i = 1'b1; data_i = 8'h00; hold_i = 1'b1;
    step();
    start_i = 1'b0; hold_i = 1'b0;
    wait_ready("busy_ready_timeout");
    repeat (20) step();
    chk("busy_one_valid", 32'(valid_cnt - v0), 32'd1);
    chk("busy_one_word", 32'(p_words - pw0), 32'd1);
    chk("busy_cs_cycle", 32'(cs_rise_cyc), 32'(c0 + 68));

    // SCK_DIV=2 back-to-back loopback with start held high.
    start2_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data2_i = w2[i];
      n = 0;
      while (ready2_o !== 1'b1 && n < 200) begin step(); n++; end
      if (ready2_o !== 1'b1) chk("d2_ready_timeout", 32'(ready2_o), 32'd1);
      exp2_q.push_back(w2[i]);
      @(posedge clk);
      #1;
    end
    start2_i = 1'b0;
    n = 0;
    while ((valid2_cnt < 3 || ready2_o !== 1'b1) && n < 300) begin step(); n++; end
    step();
    chk("d2_valid_count", 32'(valid2_cnt), 32'd3);
    chk("d2_sck_edges", 32'(sck2_edges), 32'd48);
    chk("d2_phase_errors", 32'(phase2_err), 32'd0);

    repeat (5) step();
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("ptx_q_drained", 32'(ptx_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
